// File: rtl/axi_rd_pkg.sv
// Shared state encoding, AXI constants and sizing helper for the AXI read master.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rd_data_fifo.sv
// First-word-fall-through synchronous FIFO; count output feeds the burst reservation.
module rd_data_fifo
  import axi_rd_pkg::*;
#(
  parameter int P_WIDTH = 128,
  parameter int P_DEPTH = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [P_WIDTH-1:0]        wdata,
  output logic                      full,
  input  logic                      pop,
  output logic [P_WIDTH-1:0]        rdata,
  output logic                      valid,
  output logic [clog2(P_DEPTH):0]   count
);

  localparam int PTR_W = clog2(P_DEPTH);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (PTR_W + 1)'(P_DEPTH));
  assign valid   = (count != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; empty pointers make stale words invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/axi_rd_master.sv
// AXI4 read master: one outstanding burst, R beats buffered in a FWFT FIFO for the user stream.
// Optional rresp/rid/rlast checking is built when AXI_RD_RESP_CHK_EN is defined.
module axi_rd_master
  import axi_rd_pkg::*;
#(
  parameter int         P_WR_LENGTH      = 4096,
  parameter int         P_AXI_DATA_WIDTH = 128,
  parameter int         P_AXI_ADDR_WIDTH = 32,
  parameter logic [3:0] P_AXI_ID         = 4'd0,
  parameter int         P_FIFO_DEPTH     = 512
) (
  input  logic                        i_axi_clk,
  input  logic                        i_rst_n,
  input  logic                        i_axi_u2a_rden,
  input  logic [P_AXI_ADDR_WIDTH-1:0] i_axi_u2a_addr,
  input  logic [7:0]                  i_axi_u2a_length,
  output logic                        o_buffer_ready,
  output logic [3:0]                  o_m_axi_arid,
  output logic [P_AXI_ADDR_WIDTH-1:0] o_m_axi_araddr,
  output logic [7:0]                  o_m_axi_arlen,
  output logic [2:0]                  o_m_axi_arsize,
  output logic [1:0]                  o_m_axi_arburst,
  output logic                        o_m_axi_arvalid,
  input  logic                        i_m_axi_arready,
  input  logic [3:0]                  i_m_axi_rid,
  input  logic [P_AXI_DATA_WIDTH-1:0] i_m_axi_rdata,
  input  logic [1:0]                  i_m_axi_rresp,
  input  logic                        i_m_axi_rlast,
  input  logic                        i_m_axi_rvalid,
  output logic                        o_m_axi_rready,
  output logic [P_AXI_DATA_WIDTH-1:0] o_user_rd_data,
  output logic                        o_user_rd_valid,
  input  logic                        i_user_rd_ready,
  output logic                        o_rd_err
);

  localparam int P_BURST_LEN = P_WR_LENGTH / (P_AXI_DATA_WIDTH / 8);
  localparam int P_SIZE      = clog2(P_AXI_DATA_WIDTH / 8);
  localparam int CNT_W       = clog2(P_FIFO_DEPTH) + 1;
  // Highest fill level that still leaves room for a whole burst.
  localparam logic [CNT_W-1:0] RESERVE_LIMIT = CNT_W'(P_FIFO_DEPTH - P_BURST_LEN);

  rd_state_e        state;
  logic [7:0]       beat_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             cmd_accept;
  logic             r_accept;

  assign o_m_axi_arid    = P_AXI_ID;
  assign o_m_axi_arsize  = 3'(P_SIZE);
  assign o_m_axi_arburst = BURST_INCR;

  assign cmd_accept = (state == ST_IDLE) && i_axi_u2a_rden && o_buffer_ready;
  assign r_accept   = (state == ST_DATA) && i_m_axi_rvalid && o_m_axi_rready;

  always_ff @(posedge i_axi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      o_buffer_ready  <= 1'b0;
      o_m_axi_arvalid <= 1'b0;
      o_m_axi_araddr  <= '0;
      o_m_axi_arlen   <= '0;
      o_m_axi_rready  <= 1'b0;
      beat_cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_accept) begin
            state           <= ST_AR;
            o_m_axi_araddr  <= i_axi_u2a_addr;
            o_m_axi_arlen   <= i_axi_u2a_length;
            o_m_axi_arvalid <= 1'b1;
            o_buffer_ready  <= 1'b0;
          end else begin
            o_buffer_ready  <= (fifo_count <= RESERVE_LIMIT);
          end
        end
        ST_AR: begin
          if (i_m_axi_arready) begin
            state           <= ST_DATA;
            o_m_axi_arvalid <= 1'b0;
            o_m_axi_rready  <= 1'b1;
            beat_cnt        <= '0;
          end
        end
        ST_DATA: begin
          if (r_accept) begin
            if (i_m_axi_rlast) begin
              state          <= ST_IDLE;
              o_m_axi_rready <= 1'b0;
              beat_cnt       <= '0;
            end else begin
              beat_cnt       <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rd_data_fifo #(
    .P_WIDTH (P_AXI_DATA_WIDTH),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_axi_clk),
    .rst_n (i_rst_n),
    .push  (r_accept),
    .wdata (i_m_axi_rdata),
    .full  (fifo_full),
    .pop   (i_user_rd_ready),
    .rdata (o_user_rd_data),
    .valid (o_user_rd_valid),
    .count (fifo_count)
  );

  // Reservation at command accept means a beat can never find the FIFO full.
  assert property (@(posedge i_axi_clk) disable iff (!i_rst_n) !(r_accept && fifo_full));

`ifdef AXI_RD_RESP_CHK_EN
  logic beat_err;

  // NOTE: a combinational block assigns its output on every path so no latch is inferred.
  always_comb begin
    beat_err = (i_m_axi_rresp != RESP_OKAY) ||
               (i_m_axi_rid != P_AXI_ID) ||
               (i_m_axi_rlast != (beat_cnt == o_m_axi_arlen));
  end

  always_ff @(posedge i_axi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_err <= 1'b0;
    end else if (r_accept && beat_err) begin
      o_rd_err <= 1'b1;
    end
  end
`else
  logic unused_chk;

  assign o_rd_err   = 1'b0;
  assign unused_chk = ^{i_m_axi_rid, i_m_axi_rresp, beat_cnt};
`endif

endmodule

// File: tb/tb_axi_rd_master.sv
// Self-checking bench for axi_rd_master: random AXI slave, command/data scoreboards.
module tb_axi_rd_master;

  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int DEPTH = 512;
  localparam logic [2:0] EXP_SIZE = 3'($clog2(DW / 8));
`ifdef AXI_RD_RESP_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rden = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    length = '0;
  logic          buffer_ready;
  logic [3:0]    arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [3:0]    rid = 4'd0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] user_data;
  logic          user_valid;
  logic          user_ready = 1'b0;
  logic          rd_err;

  axi_rd_master #(
    .P_WR_LENGTH      (4096),
    .P_AXI_DATA_WIDTH (DW),
    .P_AXI_ADDR_WIDTH (AW),
    .P_AXI_ID         (4'd0),
    .P_FIFO_DEPTH     (DEPTH)
  ) dut (
    .i_axi_clk        (clk),
    .i_rst_n          (rst_n),
    .i_axi_u2a_rden   (rden),
    .i_axi_u2a_addr   (addr),
    .i_axi_u2a_length (length),
    .o_buffer_ready   (buffer_ready),
    .o_m_axi_arid     (arid),
    .o_m_axi_araddr   (araddr),
    .o_m_axi_arlen    (arlen),
    .o_m_axi_arsize   (arsize),
    .o_m_axi_arburst  (arburst),
    .o_m_axi_arvalid  (arvalid),
    .i_m_axi_arready  (arready),
    .i_m_axi_rid      (rid),
    .i_m_axi_rdata    (rdata),
    .i_m_axi_rresp    (rresp),
    .i_m_axi_rlast    (rlast),
    .i_m_axi_rvalid   (rvalid),
    .o_m_axi_rready   (rready),
    .o_user_rd_data   (user_data),
    .o_user_rd_valid  (user_valid),
    .i_user_rd_ready  (user_ready),
    .o_rd_err         (rd_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;

  cmd_t          cmd_q[$];
  logic [DW-1:0] exp_q[$];

  // Slave behaviour knobs, sampled when a burst's AR handshake starts.
  int ar_delay = 0;
  int r_gap = 0;
  int err_beat = -1;
  int early_last = -1;
  int pop_mode = 0;     // 0 hold, 1 always pop, 2 random, 3 driven by main
  int cur_beat = 0;
  int bursts_done = 0;
  logic outstanding = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // User-side pop driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (pop_mode)
        0: user_ready = 1'b0;
        1: user_ready = 1'b1;
        2: user_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Data scoreboard: every user handshake pops the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && user_valid && user_ready) begin
        if (exp_q.size() == 0) check("rd_spurious", user_valid, 1'b0);
        else check("rd_data", user_data, exp_q.pop_front());
      end
    end
  end

  // A new AR must never appear while a burst is still open.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && arvalid) check("single_outstanding", outstanding, 1'b0);
    end
  end

  // AXI slave model.
  initial begin
    cmd_t          c;
    int            delay, gap, ebeat, last_beat, to;
    logic          got_last;
    logic [DW-1:0] word;
    forever begin
      @(negedge clk);
      if (!(rst_n && arvalid)) continue;
      if (cmd_q.size() == 0) begin
        check("ar_unexpected", arvalid, 1'b0);
        continue;
      end
      c = cmd_q.pop_front();
      delay = ar_delay; gap = r_gap; ebeat = err_beat;
      last_beat = (early_last >= 0) ? early_last : int'(c.len);
      check("ar_addr", araddr, c.addr);
      check("ar_len", arlen, c.len);
      check("ar_fixed", {arid, arsize, arburst}, {4'd0, EXP_SIZE, 2'b01});
      repeat (delay) begin
        @(posedge clk); #1;
        check("ar_hold", {arvalid, araddr, arlen}, {1'b1, c.addr, c.len});
      end
      arready = 1'b1;
      @(posedge clk); #1;
      arready = 1'b0;
      outstanding = 1'b1;
      check("ar_done", {arvalid, rready}, 2'b01);
      cur_beat = 0;
      got_last = 1'b0;
      for (int b = 0; b <= last_beat; b++) begin
        for (int g = 0; g < gap; g++) begin
          rvalid = 1'b0;
          @(posedge clk); #1;
        end
        if (!rst_n) break;
        word   = {$urandom, $urandom, $urandom, $urandom};
        rvalid = 1'b1;
        rdata  = word;
        rresp  = (b == ebeat) ? 2'b10 : 2'b00;
        rlast  = (b == last_beat);
        to = 0;
        while (!rready && rst_n && to < 100) begin
          @(posedge clk); #1;
          to++;
        end
        if (!rst_n) break;
        check("rready_wait", rready, 1'b1);
        if (!rready) break;
        @(posedge clk); #1;
        if (!rst_n) break;
        exp_q.push_back(word);
        cur_beat = b + 1;
        if (b == last_beat) got_last = 1'b1;
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      outstanding = 1'b0;
      if (got_last) bursts_done++;
    end
  end

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("reset_ctrl", {buffer_ready, arvalid, rready, user_valid, rd_err}, 5'b0);
    check("reset_ar", {araddr, arlen}, '0);
    exp_q.delete();
    cmd_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_reset", {buffer_ready, user_valid}, 2'b10);
  endtask

  task automatic issue_cmd(input logic [AW-1:0] a, input logic [7:0] len);
    int to;
    @(posedge clk); #1;
    to = 0;
    while (!buffer_ready && to < 5000) begin
      @(posedge clk); #1;
      to++;
    end
    check("ready_wait", buffer_ready, 1'b1);
    if (!buffer_ready) return;
    rden = 1'b1; addr = a; length = len;
    cmd_q.push_back('{addr: a, len: len});
    @(posedge clk); #1;
    rden = 1'b0;
    check("accept", {buffer_ready, arvalid}, 2'b01);
  endtask

  task automatic wait_bursts(input int target);
    int to = 0;
    while (bursts_done < target && to < 5000) begin
      @(posedge clk); #1;
      to++;
    end
    check("bursts_done", bursts_done, target);
  endtask

  task automatic wait_drain();
    int to = 0;
    while (exp_q.size() != 0 && to < 5000) begin
      @(posedge clk); #1;
      to++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drained", {exp_q.size() == 0, user_valid}, 2'b10);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done;
    apply_reset();

    // Single burst, slow arready, random user pops.
    ar_delay = 3; r_gap = 0; pop_mode = 2;
    issue_cmd(32'h0000_1000, 8'd255);
    wait_bursts(1);
    pop_mode = 1;
    wait_drain();

    // Fill the FIFO with two bursts and no pops.
    ar_delay = 1; pop_mode = 0;
    issue_cmd(32'h0000_2000, 8'd255);
    wait_bursts(2);
    repeat (3) @(posedge clk);
    #1;
    check("ready_half_full", buffer_ready, 1'b1);
    issue_cmd(32'h0000_3000, 8'd255);
    wait_bursts(3);
    repeat (3) @(posedge clk);
    #1;
    check("ready_full", {buffer_ready, user_valid}, 2'b01);
    pop_mode = 3;
    @(posedge clk); #1; user_ready = 1'b1;
    @(posedge clk); #1; user_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ready_after_one_pop", buffer_ready, 1'b0);
    pop_mode = 1;
    wait_drain();
    check("ready_after_drain", buffer_ready, 1'b1);

    // Back-to-back random commands, rvalid 1-in-3, continuous pops.
    r_gap = 2; done = bursts_done;
    for (int i = 0; i < 3; i++) begin
      ar_delay = $urandom_range(0, 4);
      issue_cmd({$urandom_range(0, 255), 12'h000}, 8'($urandom_range(8, 255)));
    end
    wait_bursts(done + 3);
    wait_drain();
    check("no_err_clean", rd_err, 1'b0);

    // Reset in the middle of the data phase.
    r_gap = 0; pop_mode = 0;
    issue_cmd(32'h0000_5000, 8'd255);
    begin
      int to = 0;
      while (cur_beat < 100 && to < 1000) begin
        @(posedge clk); #1;
        to++;
      end
      check("beat100_reached", cur_beat >= 100, 1'b1);
    end
    apply_reset();
    pop_mode = 1;

    // Error response on beat 10.
    done = bursts_done; err_beat = 10;
    issue_cmd(32'h0000_6000, 8'd255);
    wait_bursts(done + 1);
    err_beat = -1;
    wait_drain();
    check("err_resp", rd_err, EXP_ERR);
    repeat (20) @(posedge clk);
    #1;
    check("err_sticky", rd_err, EXP_ERR);
    apply_reset();

    // Early rlast on beat 200 of a 256-beat burst.
    done = bursts_done; early_last = 200;
    issue_cmd(32'h0000_7000, 8'd255);
    wait_bursts(done + 1);
    early_last = -1;
    wait_drain();
    check("err_early_last", rd_err, EXP_ERR);
    check("idle_after_early_last", buffer_ready, 1'b1);
    check("cmd_q_empty", cmd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
